game_packet_tx: RTL

Serialises each per-frame game update into a byte stream for the inter-board link UART. It sits directly downstream of the action FSM: it consumes the player data word and scored flag on each `data_out_valid` pulse and emits a framed, checksummed packet. The opponent board receives this packet and reconstructs the opponent data. Bytes leave through a valid/ready handshake to the UART transmitter.

---
 rtl/game_packet_tx_pkg.sv | 11 +
 rtl/game_packet_tx_if.sv | 20 ++
 rtl/game_packet_tx.sv | 121 ++++++++++++
 3 files changed

// File: rtl/game_packet_tx_pkg.sv
// Types shared by the link transmitter and the opponent-side deframer.
// The pending update is stored flat as {scored, data}.
package game_packet_tx_pkg;

    localparam int DATA_W        = 89;
    localparam int FRAME_BYTES   = 14;
    localparam int PAYLOAD_BYTES = FRAME_BYTES - 2;

    typedef logic [DATA_W-1:0] data_t;

endpackage

// File: rtl/game_packet_tx_if.sv
// Byte-wide valid/ready link between the packet framer and the UART transmitter.
interface game_packet_tx_if;

    logic [7:0] byte_out;
    logic       byte_out_valid;
    logic       byte_out_ready;

    modport master (
        output byte_out,
        output byte_out_valid,
        input  byte_out_ready
    );

    modport slave (
        input  byte_out,
        input  byte_out_valid,
        output byte_out_ready
    );

endinterface

// File: rtl/game_packet_tx.sv
// Frames each game update as SYNC, 12 payload bytes (MSB first) and an XOR checksum,
// with a one-entry pending buffer that merges scored flags on overwrite.
module game_packet_tx
    import game_packet_tx_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE = 8'hA5,
    parameter int         PAD_BITS  = 6
) (
    input  logic             clk_pixel_in,
    input  logic             rst_in,
    input  logic             data_in_valid,
    input  data_t            player_data_in,
    input  logic             player_scored_in,
    game_packet_tx_if.master link,
    output logic             busy_out,
    output logic             overrun_out,
    output logic [15:0]      frames_sent_out
);

    localparam int WORD_W = DATA_W + 1 + PAD_BITS;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_HEADER   = 2'd1;
    localparam logic [1:0] ST_PAYLOAD  = 2'd2;
    localparam logic [1:0] ST_CHECKSUM = 2'd3;

    localparam logic [3:0] LAST_IDX = 4'(PAYLOAD_BYTES - 1);

    logic [1:0]        state_reg;
    logic [DATA_W:0]   pend_reg;
    logic              pend_v_reg;
    logic [WORD_W-1:0] shift_reg;
    logic [7:0]        csum_reg;
    logic [7:0]        byte_reg;
    logic [3:0]        idx_reg;
    logic              overrun_reg;
    logic [15:0]       frames_sent_reg;

    logic byte_valid;
    logic load;
    logic overwrite;

    assign byte_valid = (state_reg != ST_IDLE);
    assign load       = (state_reg == ST_IDLE) && pend_v_reg;
    // An update landing in the same cycle the old entry is loaded is not an overrun.
    assign overwrite  = data_in_valid && pend_v_reg && !load;

    always_ff @(posedge clk_pixel_in or negedge rst_in) begin
        if (!rst_in) begin
            pend_reg    <= '0;
            pend_v_reg  <= 1'b0;
            overrun_reg <= 1'b0;
        end else begin
            overrun_reg <= overwrite;
            if (data_in_valid) begin
                pend_reg   <= {player_scored_in | (overwrite & pend_reg[DATA_W]), player_data_in};
                pend_v_reg <= 1'b1;
            end else if (load) begin
                pend_v_reg <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_pixel_in or negedge rst_in) begin
        if (!rst_in) begin
            state_reg       <= ST_IDLE;
            shift_reg       <= '0;
            csum_reg        <= '0;
            byte_reg        <= '0;
            idx_reg         <= '0;
            frames_sent_reg <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (load) begin
                        shift_reg <= {pend_reg, {PAD_BITS{1'b0}}};
                        csum_reg  <= '0;
                        idx_reg   <= '0;
                        byte_reg  <= SYNC_BYTE;
                        state_reg <= ST_HEADER;
                    end
                end
                ST_HEADER: begin
                    if (link.byte_out_ready) begin
                        byte_reg  <= shift_reg[WORD_W-1 -: 8];
                        state_reg <= ST_PAYLOAD;
                    end
                end
                ST_PAYLOAD: begin
                    // byte_reg always mirrors the top of shift_reg while in this state.
                    if (link.byte_out_ready) begin
                        shift_reg <= shift_reg << 8;
                        csum_reg  <= csum_reg ^ byte_reg;
                        idx_reg   <= idx_reg + 4'd1;
                        if (idx_reg == LAST_IDX) begin
                            byte_reg  <= csum_reg ^ byte_reg;
                            state_reg <= ST_CHECKSUM;
                        end else begin
                            byte_reg <= shift_reg[WORD_W-9 -: 8];
                        end
                    end
                end
                ST_CHECKSUM: begin
                    if (link.byte_out_ready) begin
                        frames_sent_reg <= frames_sent_reg + 16'd1;
                        byte_reg        <= '0;
                        state_reg       <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign link.byte_out       = byte_reg;
    assign link.byte_out_valid = byte_valid;
    assign busy_out            = byte_valid | pend_v_reg;
    assign overrun_out         = overrun_reg;
    assign frames_sent_out     = frames_sent_reg;

endmodule
